// File: rtl/zsdram_pkg.sv
// Shared SDRAM client definitions: bus widths, burst container, reader FSM
// states and the arbiter read-handshake levels.
package zsdram_pkg;

  localparam int ADDR_W    = 24;
  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 4;

  localparam logic ARB_REQ_ON  = 1'b1;
  localparam logic ARB_REQ_OFF = 1'b0;

  // Word 0 of a burst is the first word returned (Data1).
  typedef logic [BURST_LEN-1:0][DATA_W-1:0] burst_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CHECK      = 3'd1,
    ST_REQ        = 3'd2,
    ST_RELEASE    = 3'd3,
    ST_DONE_FETCH = 3'd4
  } rd_state_e;

  function automatic logic [ADDR_W-1:0] burst_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [31:0] line,
                                                   input logic [31:0] stride,
                                                   input logic [31:0] col);
    logic [31:0] sum;
    sum = {8'd0, base} + line * stride + col;
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/zsdram_frame_reader_if.sv
// Arbiter read port as seen by one requester.
// Handshake: master raises oRd_Req with a stable oRd_Addr and holds both until
// it samples iRd_Done=1; iRd_Data1..4 are valid only in that Done cycle; the
// master then drops oRd_Req for at least one cycle before the next request.
interface zsdram_frame_reader_if;
  import zsdram_pkg::*;

  logic              oRd_Req;
  logic [ADDR_W-1:0] oRd_Addr;
  logic              iRd_Done;
  logic [DATA_W-1:0] iRd_Data1;
  logic [DATA_W-1:0] iRd_Data2;
  logic [DATA_W-1:0] iRd_Data3;
  logic [DATA_W-1:0] iRd_Data4;

  modport master (
    output oRd_Req, oRd_Addr,
    input  iRd_Done, iRd_Data1, iRd_Data2, iRd_Data3, iRd_Data4
  );

  modport slave (
    input  oRd_Req, oRd_Addr,
    output iRd_Done, iRd_Data1, iRd_Data2, iRd_Data3, iRd_Data4
  );
endinterface

// File: rtl/zsdram_frame_reader_fifo.sv
// Synchronous FIFO of whole bursts with show-ahead head and a flush that
// takes priority over push and pop.
module zburst_fifo
  import zsdram_pkg::*;
#(
  parameter int FIFO_ENTRIES = 4,
  localparam int PTR_W = $clog2(FIFO_ENTRIES),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  burst_t           push_data_i,
  input  logic             pop_i,
  output burst_t           head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  burst_t           mem_q [FIFO_ENTRIES];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_ENTRIES));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/zsdram_frame_reader.sv
// Display-side SDRAM read client: fetches a frame in 4-word bursts through the
// arbiter read port and serves it one pixel at a time from a burst FIFO.
module zsdram_frame_reader
  import zsdram_pkg::*;
#(
  parameter int                H_RES        = 480,
  parameter int                V_RES        = 272,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 24'h000000,
  parameter int                LINE_STRIDE  = 512,
  parameter int                FIFO_ENTRIES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  iFrame_Start,
  zsdram_frame_reader_if.master rd,
  input  logic                  iPix_Rd,
  output logic [DATA_W-1:0]     oPix_Data,
  output logic                  oPix_Valid,
  output logic                  oUnderflow,
  output logic                  oFrame_Done,
  output rd_state_e             dbg_state_o
);

  localparam int COL_W        = $clog2(H_RES);
  localparam int LINE_W       = $clog2(V_RES + 1);
  localparam int TOTAL_BURSTS = (H_RES / BURST_LEN) * V_RES;
  localparam int PB_W         = $clog2(TOTAL_BURSTS + 1);
  localparam int CNT_W        = $clog2(FIFO_ENTRIES) + 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_RES - BURST_LEN);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_RES - 1);
  localparam logic [PB_W-1:0]   POP_LAST  = PB_W'(TOTAL_BURSTS - 1);

  rd_state_e         state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              reserved_q, reserved_d;
  logic              discard_q, discard_d;
  logic              fetched_q, fetched_d;
  logic [1:0]        word_q, word_d;
  logic [PB_W-1:0]   popped_q, popped_d;
  logic              underflow_q, underflow_d;
  logic              frame_done_q, frame_done_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  burst_t            fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              space_ok, req_out;

  zburst_fifo #(.FIFO_ENTRIES(FIFO_ENTRIES)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (iFrame_Start),
    .push_i      (fifo_push),
    .push_data_i ({rd.iRd_Data4, rd.iRd_Data3, rd.iRd_Data2, rd.iRd_Data1}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // An in-flight burst already owns a slot, so the FIFO can never overflow.
  assign space_ok = !fifo_full && ((int'(fifo_count) + int'(reserved_q)) < FIFO_ENTRIES);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    line_d     = line_q;
    addr_d     = addr_q;
    reserved_d = reserved_q;
    discard_d  = discard_q;
    fetched_d  = fetched_q;
    fifo_push  = 1'b0;
    req_out    = ARB_REQ_OFF;
    case (state_q)
      ST_IDLE: ;
      ST_CHECK: begin
        if (!iFrame_Start) begin
          if (fetched_q) begin
            state_d = ST_DONE_FETCH;
          end else if (en && space_ok) begin
            state_d    = ST_REQ;
            reserved_d = 1'b1;
            addr_d     = burst_addr(BASE_ADDR, 32'(line_q), 32'(LINE_STRIDE), 32'(col_q));
          end
        end
      end
      ST_REQ: begin
        req_out = ARB_REQ_ON;
        if (rd.iRd_Done) begin
          state_d    = ST_RELEASE;
          reserved_d = 1'b0;
          discard_d  = 1'b0;
          if (!discard_q && !iFrame_Start) begin
            fifo_push = 1'b1;
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (line_q == LINE_LAST) fetched_d = 1'b1;
              else                     line_d    = line_q + LINE_W'(1);
            end else begin
              col_d = col_q + COL_W'(BURST_LEN);
            end
          end
        end
      end
      ST_RELEASE:    state_d = ST_CHECK;
      ST_DONE_FETCH: ;
      default:       state_d = ST_IDLE;
    endcase
    // A new frame never aborts a request in flight; its data is dropped instead.
    if (iFrame_Start) begin
      col_d     = '0;
      line_d    = '0;
      fetched_d = 1'b0;
      if (state_q == ST_REQ) begin
        if (!rd.iRd_Done) discard_d = 1'b1;
      end else begin
        state_d = ST_CHECK;
      end
    end
  end

  always_comb begin
    word_d       = word_q;
    popped_d     = popped_q;
    underflow_d  = underflow_q;
    frame_done_d = 1'b0;
    fifo_pop     = 1'b0;
    if (iFrame_Start) begin
      word_d      = '0;
      popped_d    = '0;
      underflow_d = 1'b0;
    end else if (iPix_Rd) begin
      if (fifo_empty) begin
        underflow_d = 1'b1;
      end else begin
        word_d = word_q + 2'd1;
        if (word_q == 2'd3) begin
          fifo_pop = 1'b1;
          popped_d = popped_q + PB_W'(1);
          if (popped_q == POP_LAST) frame_done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      line_q       <= '0;
      addr_q       <= '0;
      reserved_q   <= 1'b0;
      discard_q    <= 1'b0;
      fetched_q    <= 1'b0;
      word_q       <= '0;
      popped_q     <= '0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      addr_q       <= addr_d;
      reserved_q   <= reserved_d;
      discard_q    <= discard_d;
      fetched_q    <= fetched_d;
      word_q       <= word_d;
      popped_q     <= popped_d;
      underflow_q  <= underflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd.oRd_Req  = req_out;
  assign rd.oRd_Addr = addr_q;
  assign oPix_Valid  = !fifo_empty;
  assign oPix_Data   = fifo_empty ? '0 : fifo_head[word_q];
  assign oUnderflow  = underflow_q;
  assign oFrame_Done = frame_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_zsdram_frame_reader.sv
// Bench for zsdram_frame_reader: arbiter model with fixed latency, pixel
// scoreboard fed by the model and directed fill/flush/enable scenarios.
module tb_zsdram_frame_reader;
  import zsdram_pkg::*;

  localparam int          H        = 16;
  localparam int          V        = 3;
  localparam int          STRIDE   = 32;
  localparam logic [23:0] BASE     = 24'hFFFFE0;
  localparam int          N_ENT    = 4;
  localparam int          DONE_LAT = 5;
  localparam logic [23:0] ADDR8    = BASE + 24'd8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, en, iFrame_Start, iPix_Rd;
  logic [15:0] oPix_Data;
  logic oPix_Valid, oUnderflow, oFrame_Done;
  rd_state_e dbg_state;

  always #5 clk = ~clk;

  zsdram_frame_reader_if rd_if ();

  zsdram_frame_reader #(
    .H_RES(H), .V_RES(V), .BASE_ADDR(BASE), .LINE_STRIDE(STRIDE), .FIFO_ENTRIES(N_ENT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .iFrame_Start(iFrame_Start), .rd(rd_if.master),
    .iPix_Rd(iPix_Rd), .oPix_Data(oPix_Data), .oPix_Valid(oPix_Valid),
    .oUnderflow(oUnderflow), .oFrame_Done(oFrame_Done), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  int busy, cnt, mline, mcol, pops, fd_pulses, req_fs, req_total;
  bit disc;
  logic [23:0] lat_addr;
  logic [15:0] w [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_addr();
    logic [31:0] s;
    s = {8'd0, BASE} + 32'(mline) * 32'(STRIDE) + 32'(mcol);
    return s[23:0];
  endfunction

  // ---------------- arbiter model + pixel monitor ----------------
  initial begin
    rd_if.iRd_Done = 1'b0;
    rd_if.iRd_Data1 = '0; rd_if.iRd_Data2 = '0; rd_if.iRd_Data3 = '0; rd_if.iRd_Data4 = '0;
    busy = 0; cnt = 0; disc = 0; mline = 0; mcol = 0;
    pops = 0; fd_pulses = 0; req_fs = 0; req_total = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0;
        rd_if.iRd_Done = 1'b0;
      end else begin
        if (oFrame_Done) begin
          fd_pulses++;
          chk("frame_done_pop", pops, H * V);
        end
        if (!oPix_Valid) chk("pix_zero_empty", oPix_Data, 0);
        if (!iFrame_Start && iPix_Rd && oPix_Valid) begin
          chk("pix_avail", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("pix_data", oPix_Data, exp_q.pop_front());
          pops++;
        end
        if (rd_if.iRd_Done) begin
          rd_if.iRd_Done = 1'b0;
          busy = 0;
          chk("req_release", rd_if.oRd_Req, 0);
        end else if (busy != 0) begin
          cnt++;
          chk("req_hold", {rd_if.oRd_Req, rd_if.oRd_Addr}, {1'b1, lat_addr});
          if (cnt == DONE_LAT) begin
            for (int k = 0; k < 4; k++) w[k] = 16'($urandom_range(0, 65535));
            rd_if.iRd_Data1 = w[0]; rd_if.iRd_Data2 = w[1];
            rd_if.iRd_Data3 = w[2]; rd_if.iRd_Data4 = w[3];
            rd_if.iRd_Done = 1'b1;
            if (!disc) begin
              for (int k = 0; k < 4; k++) exp_q.push_back(w[k]);
              mcol += 4;
              if (mcol == H) begin mcol = 0; mline++; end
            end
          end
        end else if (rd_if.oRd_Req) begin
          busy = 1; cnt = 1; disc = 0;
          lat_addr = rd_if.oRd_Addr;
          req_fs++; req_total++;
          chk("req_addr", rd_if.oRd_Addr, model_addr());
        end
        if (iFrame_Start) begin
          exp_q.delete();
          mline = 0; mcol = 0; pops = 0; fd_pulses = 0; req_fs = 0;
          if (busy != 0) disc = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_frame_start();
    @(posedge clk); #1 iFrame_Start = 1'b1;
    @(posedge clk); #1 iFrame_Start = 1'b0;
  endtask

  task automatic wait_req_level(input logic lvl, input string tag);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (rd_if.oRd_Req == lvl) found = 1;
    end
    chk(tag, found, 1);
  endtask

  // ---------------- main sequence ----------------
  int r0;
  bit found;
  initial begin
    rst = 1'b1; en = 1'b1; iFrame_Start = 1'b0; iPix_Rd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", rd_if.oRd_Req, 0);
    chk("rst_addr", rd_if.oRd_Addr, 0);
    chk("rst_pix_data", oPix_Data, 0);
    chk("rst_pix_valid", oPix_Valid, 0);
    chk("rst_underflow", oUnderflow, 0);
    chk("rst_frame_done", oFrame_Done, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1 rst = 1'b0;
    step(10);
    chk("idle_no_req", req_total, 0);
    chk("idle_state", dbg_state, ST_IDLE);

    // Pop from an empty FIFO.
    iPix_Rd = 1'b1;
    step(1);
    iPix_Rd = 1'b0;
    @(negedge clk);
    chk("underflow_set", oUnderflow, 1);
    chk("underflow_data", oPix_Data, 0);

    // Frame start: underflow cleared, first request two cycles later.
    pulse_frame_start();
    @(negedge clk);
    chk("fs_underflow_clr", oUnderflow, 0);
    chk("fs_c1_state", dbg_state, ST_CHECK);
    chk("fs_c1_req", rd_if.oRd_Req, 0);
    @(negedge clk);
    chk("fs_c2_req", rd_if.oRd_Req, 1);
    chk("fs_c2_addr", rd_if.oRd_Addr, BASE);

    // No pops: FIFO fills after exactly N_ENT requests.
    step(60);
    chk("fill_req_count", req_fs, N_ENT);
    chk("fill_req_low", rd_if.oRd_Req, 0);
    chk("fill_valid", oPix_Valid, 1);

    // One burst popped frees exactly one slot.
    iPix_Rd = 1'b1;
    step(4);
    iPix_Rd = 1'b0;
    step(30);
    chk("refill_req_count", req_fs, N_ENT + 1);

    // Drain the whole frame.
    iPix_Rd = 1'b1;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step(1);
      if (fd_pulses != 0) found = 1;
    end
    chk("frame_done_seen", found, 1);
    step(30);
    chk("frame_done_once", fd_pulses, 1);
    chk("frame_req_total", req_fs, (H / 4) * V);
    chk("frame_state", dbg_state, ST_DONE_FETCH);
    chk("frame_q_empty", exp_q.size(), 0);
    chk("frame_underflow", oUnderflow, 1);
    chk("frame_empty_data", oPix_Data, 0);

    iPix_Rd = 1'b0;
    pulse_frame_start();
    chk("fs2_underflow_clr", oUnderflow, 0);
    iPix_Rd = 1'b1;

    // Frame start while the request at column 8 is outstanding.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (rd_if.oRd_Req && rd_if.oRd_Addr == ADDR8) found = 1;
    end
    chk("wait_req_addr8", found, 1);
    iFrame_Start = 1'b1;
    @(posedge clk); #1 iFrame_Start = 1'b0;
    chk("abort_req_held", rd_if.oRd_Req, 1);
    wait_req_level(1'b0, "abort_req_fall");
    wait_req_level(1'b1, "abort_next_req");
    chk("abort_next_addr", rd_if.oRd_Addr, BASE);

    // en=0 while a request is outstanding.
    wait_req_level(1'b0, "en_req_fall");
    wait_req_level(1'b1, "en_req_rise");
    en = 1'b0;
    step(40);
    r0 = req_fs;
    chk("en0_req_low", rd_if.oRd_Req, 0);
    step(30);
    chk("en0_no_new_req", req_fs, r0);
    chk("en0_state", dbg_state, ST_CHECK);
    en = 1'b1;
    @(negedge clk);
    chk("en1_same_cycle", rd_if.oRd_Req, 0);
    @(negedge clk);
    chk("en1_next_cycle", rd_if.oRd_Req, 1);

    // Random pop pattern across a fresh frame.
    pulse_frame_start();
    for (int i = 0; i < 300; i++) begin
      iPix_Rd = 1'($urandom_range(0, 1));
      step(1);
    end
    iPix_Rd = 1'b1;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step(1);
      if (dbg_state == ST_DONE_FETCH && !oPix_Valid) found = 1;
    end
    chk("rand_frame_end", found, 1);
    step(5);
    chk("rand_frame_done", fd_pulses, 1);
    chk("rand_req_total", req_fs, (H / 4) * V);
    chk("rand_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
